krz_uart_tx: RTL and testbench

Memory-mapped 8N1 UART transmitter with a transmit FIFO, attached as a slave on the Kronos Zero Degree system bus (`sys_*`) downstream of `krz_intercon`, alongside the GPIO registers. The core writes bytes into the FIFO. A baud-rate state machine serialises them onto `txd`. A status register exposes FIFO and shifter state for polling.

---
 rtl/krz_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_krz_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/krz_uart_tx.sv
// krz_uart_tx: memory-mapped 8N1 UART transmitter with a circular transmit FIFO.
// Registers TXDATA (0x0), STATUS (0x4), BAUDDIV (0x8); every access gets a one-cycle ack.
module krz_uart_tx #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd207
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [7:0]  sys_adr_i,
    input  logic [31:0] sys_dat_i,
    output logic [31:0] sys_dat_o,
    input  logic        sys_stb_i,
    input  logic        sys_we_i,
    output logic        sys_ack_o,
    output logic        txd,
    output logic        tx_empty_o
);
    localparam int unsigned     AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = DEPTH[AW:0];
    localparam logic [AW-1:0]   PTR_ONE  = 1;
    localparam logic [AW:0]     CNT_ONE  = 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;
    logic [15:0]     div_q, div_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    state_e          state_q, state_d;
    logic [15:0]     baud_cnt_q, baud_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            txd_q, txd_d;
    logic            tx_empty_q, tx_empty_d;
    logic [7:0]      mem_q [DEPTH];

    logic            accept, mapped, push, pop, fifo_full, fifo_empty, bit_end;
    logic [1:0]      reg_sel;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign unused_bits = ^{sys_dat_i[31:16], sys_adr_i[1:0]};

    // Bus decode and register file
    always_comb begin
        accept     = sys_stb_i && !ack_q;
        mapped     = (sys_adr_i[7:4] == 4'h0);
        reg_sel    = sys_adr_i[3:2];
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        // Fullness is judged on the pre-pop count, so a same-cycle pop never rescues a push.
        push       = accept && sys_we_i && mapped && (reg_sel == 2'd0) && !fifo_full;
        ack_d      = accept;
        dat_d      = dat_q;
        div_d      = div_q;
        rdata      = '0;
        if (mapped) begin
            case (reg_sel)
                2'd1:    rdata = {29'd0, state_q != StIdle, fifo_empty, fifo_full};
                2'd2:    rdata = {16'd0, div_q};
                default: rdata = '0;
            endcase
        end
        if (accept) begin
            if (sys_we_i) begin
                if (mapped && reg_sel == 2'd2) begin
                    div_d = sys_dat_i[15:0];
                end
            end else begin
                dat_d = rdata;
            end
        end
    end

    // Shifter FSM: every bit reloads baud_cnt from BAUDDIV, so a divisor change lands on a boundary.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        txd_d      = txd_q;
        pop        = 1'b0;
        bit_end    = (baud_cnt_q == 16'd0);
        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_d    = mem_q[rd_ptr_q];
                    baud_cnt_d = div_q;
                    txd_d      = 1'b0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    txd_d      = shreg_q[0];
                    bit_idx_d  = 3'd0;
                    baud_cnt_d = div_q;
                    state_d    = StData;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_cnt_d = div_q;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        txd_d     = shreg_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shreg_d    = mem_q[rd_ptr_q];
                        baud_cnt_d = div_q;
                        txd_d      = 1'b0;
                        state_d    = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
        tx_empty_d = (count_d == '0) && (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            div_q      <= DEFAULT_DIV;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            txd_q      <= 1'b1;
            tx_empty_q <= 1'b1;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            div_q      <= div_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            txd_q      <= txd_d;
            tx_empty_q <= tx_empty_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sys_dat_i[7:0];
        end
    end

    assign sys_ack_o  = ack_q;
    assign sys_dat_o  = dat_q;
    assign txd        = txd_q;
    assign tx_empty_o = tx_empty_q;

endmodule

// File: tb/tb_krz_uart_tx.sv
// Scoreboard bench for krz_uart_tx: writes push expected frames, a line monitor
// rebuilds each frame's waveform from bit lengths and compares it cycle by cycle.
module tb_krz_uart_tx;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstz;
    logic [7:0]  sys_adr_i;
    logic [31:0] sys_dat_i;
    logic [31:0] sys_dat_o;
    logic        sys_stb_i;
    logic        sys_we_i;
    logic        sys_ack_o;
    logic        txd;
    logic        tx_empty_o;

    krz_uart_tx #(
        .DEPTH      (DEPTH),
        .DEFAULT_DIV(16'd207)
    ) dut (
        .clk       (clk),
        .rstz      (rstz),
        .sys_adr_i (sys_adr_i),
        .sys_dat_i (sys_dat_i),
        .sys_dat_o (sys_dat_o),
        .sys_stb_i (sys_stb_i),
        .sys_we_i  (sys_we_i),
        .sys_ack_o (sys_ack_o),
        .txd       (txd),
        .tx_empty_o(tx_empty_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    // Reference model state: expected bytes with per-bit lengths; FIFO occupancy is pushed - starts.
    logic [7:0] exp_data[$];
    int         exp_lens[$];
    bit         exp_wave[$];
    int         start_cycs[$];
    int         pushed = 0;
    int         starts = 0;
    int         last_start_cyc = 0;
    bit         in_frame = 1'b0;
    bit         frame_bad = 1'b0;
    bit         rogue = 1'b0;
    logic [7:0] mon_byte;
    logic [9:0] mon_lvls;
    int         mon_len, mon_pos, bad_pos;
    logic       bad_got;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
        end
    endtask

    // Line monitor
    always @(negedge clk) begin
        if (!rstz) begin
            in_frame = 1'b0;
            rogue    = 1'b0;
            exp_wave.delete();
        end else begin
            if (!in_frame && !rogue && txd === 1'b0) begin
                starts++;
                last_start_cyc = cyc;
                start_cycs.push_back(cyc);
                if (exp_data.size() == 0) begin
                    rogue = 1'b1;
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_frame: txd fell at cycle %0d, required no frame", cyc);
                end else begin
                    mon_byte = exp_data.pop_front();
                    mon_lvls = {1'b1, mon_byte, 1'b0};
                    for (int k = 0; k < 10; k++) begin
                        mon_len = exp_lens.pop_front();
                        repeat (mon_len) exp_wave.push_back(mon_lvls[k]);
                    end
                    in_frame  = 1'b1;
                    frame_bad = 1'b0;
                    mon_pos   = 0;
                end
            end
            if (in_frame) begin
                if (txd !== exp_wave[0] && !frame_bad) begin
                    frame_bad = 1'b1;
                    bad_pos   = mon_pos;
                    bad_got   = txd;
                end
                void'(exp_wave.pop_front());
                mon_pos++;
                if (exp_wave.size() == 0) begin
                    in_frame = 1'b0;
                    compared++;
                    if (frame_bad) begin
                        mismatched++;
                        $display("FAIL frame_%02h: cycle %0d of frame txd=%b, required %b",
                                 mon_byte, bad_pos, bad_got, ~bad_got);
                    end
                end
            end
        end
    end

    task automatic bus_access(input logic we, input logic [7:0] adr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output bit acked);
        acked = 1'b0;
        rdata = '0;
        @(negedge clk);
        sys_stb_i = 1'b1;
        sys_we_i  = we;
        sys_adr_i = adr;
        sys_dat_i = wdata;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (sys_ack_o) begin
                acked = 1'b1;
                rdata = sys_dat_o;
            end
        end
        sys_stb_i = 1'b0;
        sys_we_i  = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b, input int len_a, input int len_b);
        logic [31:0] rd;
        bit ok;
        bus_access(1'b1, 8'h00, {24'h0, b}, rd, ok);
        check("txdata_ack", 32'(ok), 32'd1);
        if (ok && (pushed - starts) < DEPTH) begin
            exp_data.push_back(b);
            for (int k = 0; k < 10; k++) exp_lens.push_back(k < 4 ? len_a : len_b);
            pushed++;
        end
    endtask

    task automatic write_div(input int div);
        logic [31:0] rd;
        bit ok;
        bus_access(1'b1, 8'h08, 32'(div), rd, ok);
        check("bauddiv_ack", 32'(ok), 32'd1);
    endtask

    task automatic read_reg(input string name, input logic [7:0] adr, input logic [31:0] want);
        logic [31:0] rd;
        bit ok;
        bus_access(1'b0, adr, 32'hDEAD_BEEF, rd, ok);
        check({name, "_ack"}, 32'(ok), 32'd1);
        check(name, rd, want);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (!(tx_empty_o && !in_frame && exp_data.size() == 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(n < max_cyc), 32'd1);
    endtask

    int          d, n, s0, n0, ack_cyc, empty_cyc, cnt;
    logic [31:0] rd;
    bit          ok;

    initial begin
        rstz      = 1'b0;
        sys_stb_i = 1'b0;
        sys_we_i  = 1'b0;
        sys_adr_i = '0;
        sys_dat_i = '0;
        repeat (3) @(posedge clk);
        #1 rstz = 1'b1;

        // 1: reset state
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_tx_empty", 32'(tx_empty_o), 32'd1);
        read_reg("reset_status", 8'h04, 32'h2);
        read_reg("reset_bauddiv", 8'h08, 32'd207);
        read_reg("reset_txdata", 8'h00, 32'd0);

        // 2: single 0x55 frame at 4 cycles per bit
        write_div(3);
        start_cycs.delete();
        tx_write(8'h55, 4, 4);
        ack_cyc = cyc;
        n = 0;
        while (!tx_empty_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        empty_cyc = cyc;
        check("t2_start_seen", 32'(start_cycs.size()), 32'd1);
        s0 = (start_cycs.size() > 0) ? start_cycs[0] : -1000;
        check("t2_write_to_line", 32'(s0 - ack_cyc), 32'd1);
        check("t2_empty_at_stop_end", 32'(empty_cyc - s0), 32'd40);
        wait_idle(400);

        // 3: back-to-back frames at one cycle per bit
        write_div(0);
        start_cycs.delete();
        tx_write(8'hA5, 1, 1);
        tx_write(8'h3C, 1, 1);
        wait_idle(400);
        check("t3_frames", 32'(start_cycs.size()), 32'd2);
        if (start_cycs.size() == 2) check("t3_contiguous", 32'(start_cycs[1] - start_cycs[0]), 32'd10);

        // 4: overfill the FIFO
        write_div(15);
        n0 = starts;
        for (int i = 0; i < 10; i++) tx_write(8'(i), 16, 16);
        bus_access(1'b0, 8'h04, '0, rd, ok);
        cnt = pushed - starts;
        check("t4_status_ack", 32'(ok), 32'd1);
        check("t4_status", rd & 32'hFFFF_FFFB, {30'd0, cnt == 0, cnt == DEPTH});
        wait_idle(20000);
        check("t4_frames_sent", 32'(starts - n0), 32'd9);

        // 5: divisor change during data bit 2
        write_div(7);
        n0 = starts;
        tx_write(8'hC3, 8, 2);
        n = 0;
        while (starts == n0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_start_seen", 32'(starts - n0), 32'd1);
        s0 = last_start_cyc;
        while (cyc < s0 + 25) @(negedge clk);
        write_div(1);
        wait_idle(400);

        // Randomised traffic, divisor changed only while idle
        for (int r = 0; r < 6; r++) begin
            d = $urandom_range(0, 3);
            n = $urandom_range(1, 12);
            write_div(d);
            for (int i = 0; i < n; i++) begin
                tx_write(8'($urandom), d + 1, d + 1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle(20000);
        end

        // 6: reset mid-frame with bytes queued
        write_div(3);
        n0 = starts;
        for (int i = 0; i < 4; i++) tx_write(8'hF0 + 8'(i), 4, 4);
        n = 0;
        while (starts == n0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_start_seen", 32'(starts - n0), 32'd1);
        s0 = last_start_cyc;
        while (cyc < s0 + 14) @(negedge clk);
        rstz = 1'b0;
        @(posedge clk);
        #1;
        check("t6_reset_txd", 32'(txd), 32'd1);
        check("t6_reset_tx_empty", 32'(tx_empty_o), 32'd1);
        exp_data.delete();
        exp_lens.delete();
        start_cycs.delete();
        pushed = 0;
        starts = 0;
        @(posedge clk);
        #1 rstz = 1'b1;
        read_reg("t6_unmapped_read", 8'hF0, 32'd0);
        repeat (300) @(negedge clk);
        check("t6_no_frames", 32'(starts), 32'd0);
        check("t6_idle_txd", 32'(txd), 32'd1);
        check("t6_idle_tx_empty", 32'(tx_empty_o), 32'd1);
        read_reg("t6_bauddiv_reset", 8'h08, 32'd207);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
